// File: rtl/video_pkg.sv
// Shared constants for the video test-pattern source: 1280x720 timing, pattern
// select encoding and the 24-bit colours used by the bars, solid and checker fills.
package video_pkg;

  localparam int VP_H_ACTIVE = 1280;
  localparam int VP_H_FP     = 110;
  localparam int VP_H_SYNC   = 40;
  localparam int VP_H_BP     = 220;
  localparam int VP_V_ACTIVE = 720;
  localparam int VP_V_FP     = 5;
  localparam int VP_V_SYNC   = 5;
  localparam int VP_V_BP     = 20;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_SOLID    = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_SOLID   = 24'hE0A080;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = COL_WHITE;
      3'd1:    rgb = COL_YELLOW;
      3'd2:    rgb = COL_CYAN;
      3'd3:    rgb = COL_GREEN;
      3'd4:    rgb = COL_MAGENTA;
      3'd5:    rgb = COL_RED;
      3'd6:    rgb = COL_BLUE;
      default: rgb = COL_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_stream_gen_if.sv
// Video stream bundle: active flag, syncs, {R,G,B} pixel and frame-start marker.
// The source drives it through the master modport, a consumer samples it through slave.
interface video_stream_gen_if;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [23:0] pixel_out;
  logic        frame_start;

  modport master (
    output de_out, hsync_out, vsync_out, pixel_out, frame_start
  );

  modport slave (
    input de_out, hsync_out, vsync_out, pixel_out, frame_start
  );
endinterface

// File: rtl/video_pattern_lut.sv
// Combinational pattern fill: maps (pattern, x, y bit 4, bar index) to a 24-bit RGB value.
module video_pattern_lut
  import video_pkg::*;
(
  input  pattern_e    i_pattern,
  input  logic [7:0]  i_x,
  input  logic        i_y_b4,
  input  logic [2:0]  i_bar_idx,
  output logic [23:0] o_rgb
);

  logic [23:0] w_gradient;

  for (genvar gi = 0; gi < 3; gi++) begin : g_grad
    assign w_gradient[gi*8 +: 8] = i_x;
  end

  always_comb begin
    o_rgb = COL_BLACK;
    case (i_pattern)
      PAT_BARS:     o_rgb = bar_colour(i_bar_idx);
      PAT_GRADIENT: o_rgb = w_gradient;
      PAT_SOLID:    o_rgb = COL_SOLID;
      PAT_CHECKER:  o_rgb = (i_x[4] ^ i_y_b4) ? COL_WHITE : COL_BLACK;
      default:      o_rgb = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/video_stream_gen.sv
// Raster timing generator with test-pattern fill, driving the de/hsync/vsync/RGB stream.
// Define VSG_SCROLL_EN to scroll the gradient and checker patterns by one pixel per frame.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VP_H_ACTIVE,
  parameter int H_FP     = VP_H_FP,
  parameter int H_SYNC   = VP_H_SYNC,
  parameter int H_BP     = VP_H_BP,
  parameter int V_ACTIVE = VP_V_ACTIVE,
  parameter int V_FP     = VP_V_FP,
  parameter int V_SYNC   = VP_V_SYNC,
  parameter int V_BP     = VP_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         pattern_sel,
  video_stream_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 8 / 5 bits wide so the pattern can always tap x[7:0] and y[4].
  localparam int H_W   = ($clog2(H_TOTAL + 1) > 8) ? $clog2(H_TOTAL + 1) : 8;
  localparam int V_W   = ($clog2(V_TOTAL + 1) > 5) ? $clog2(V_TOTAL + 1) : 5;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int B_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEGIN  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEGIN  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [B_W-1:0] BAR_RELOAD = B_W'(BAR_W - 1);

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic [B_W-1:0] r_bar_cnt;
  logic [2:0]     r_bar_idx;
  pattern_e       r_pattern;
  logic           r_de;
  logic           r_hsync;
  logic           r_vsync;
  logic [23:0]    r_pixel;
  logic           r_frame_start;

  logic           w_h_wrap;
  logic           w_v_wrap;
  logic           w_origin;
  logic           w_de;
  logic           w_hsync;
  logic           w_vsync;
  pattern_e       w_pattern;
  logic [7:0]     w_x;
  logic [23:0]    w_rgb;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_de     = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign w_hsync  = (r_h_cnt >= HS_BEGIN) && (r_h_cnt < HS_END);
  assign w_vsync  = (r_v_cnt >= VS_BEGIN) && (r_v_cnt < VS_END);

  // Pixel (0,0) already uses the newly sampled select so a whole frame shares one pattern.
  assign w_pattern = w_origin ? pattern_e'(pattern_sel) : r_pattern;

`ifdef VSG_SCROLL_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (en && w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign w_x = r_h_cnt[7:0] + r_frame_cnt;
`else
  assign w_x = r_h_cnt[7:0];
`endif

  video_pattern_lut u_lut (
    .i_pattern (w_pattern),
    .i_x       (w_x),
    .i_y_b4    (r_v_cnt[4]),
    .i_bar_idx (r_bar_idx),
    .o_rgb     (w_rgb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_bar_cnt     <= BAR_RELOAD;
      r_bar_idx     <= '0;
      r_pattern     <= PAT_BARS;
      r_de          <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_pixel       <= '0;
      r_frame_start <= 1'b0;
    end else if (en) begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end
      // Bar index tracks h_cnt by counting down each bar width instead of dividing.
      if (w_h_wrap) begin
        r_bar_cnt <= BAR_RELOAD;
        r_bar_idx <= '0;
      end else if (r_bar_cnt == '0) begin
        r_bar_cnt <= BAR_RELOAD;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt - 1'b1;
      end
      if (w_origin) begin
        r_pattern <= pattern_e'(pattern_sel);
      end
      r_de          <= w_de;
      r_hsync       <= w_hsync ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vsync ? SYNC_POL : ~SYNC_POL;
      r_pixel       <= w_de ? w_rgb : '0;
      r_frame_start <= w_origin;
    end
  end

  assign vid.de_out      = r_de;
  assign vid.hsync_out   = r_hsync;
  assign vid.vsync_out   = r_vsync;
  assign vid.pixel_out   = r_pixel;
  assign vid.frame_start = r_frame_start;

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen on a 24x8 raster: a position-based model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_video_stream_gen;

  localparam int H_ACT  = 16;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 3;
  localparam int V_ACT  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int F_TOT  = H_TOT * V_TOT;
  localparam bit SYNC_POL = 1'b1;
`ifdef VSG_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  localparam logic [23:0] BAR_LIT [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;

  int tests_run = 0;
  int tests_failed = 0;

  video_stream_gen_if vid ();

  video_stream_gen #(
    .H_ACTIVE (H_ACT),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pattern_sel (pattern_sel),
    .vid         (vid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %06h, required %06h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pixel(input int h, input int v, input int pat, input int frame);
    logic [7:0] xb;
    if (h >= H_ACT || v >= V_ACT) return 24'h000000;
    xb = 8'(h + SCROLL * (frame % 256));
    case (pat)
      0:       return BAR_LIT[h / (H_ACT / 8)];
      1:       return {xb, xb, xb};
      2:       return 24'hE0A080;
      default: return ((xb[4] ^ (((v >> 4) & 1) != 0))) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Model: the output shows raster position m_pos = number of enabled edges since reset, minus one.
  bit          live = 1'b0;
  int          m_pos = 0;
  int          m_pat = 0;
  int          m_h = 0;
  int          m_v = 0;
  logic        e_de = 1'b0;
  logic        e_hs = ~SYNC_POL;
  logic        e_vs = ~SYNC_POL;
  logic        e_fs = 1'b0;
  logic [23:0] e_pix = 24'h0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        live  = 1'b1;
        m_pos = 0;
        m_pat = 0;
        e_de  = 1'b0;
        e_hs  = ~SYNC_POL;
        e_vs  = ~SYNC_POL;
        e_fs  = 1'b0;
        e_pix = 24'h0;
      end else if (en) begin
        m_h = m_pos % H_TOT;
        m_v = (m_pos / H_TOT) % V_TOT;
        if (m_h == 0 && m_v == 0) m_pat = int'(pattern_sel);
        e_de  = (m_h < H_ACT) && (m_v < V_ACT);
        e_hs  = (m_h >= H_ACT + H_FP && m_h < H_ACT + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        e_vs  = (m_v >= V_ACT + V_FP && m_v < V_ACT + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        e_fs  = (m_h == 0 && m_v == 0);
        e_pix = model_pixel(m_h, m_v, m_pat, m_pos / F_TOT);
        m_pos++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        chk("cyc_de", 32'(vid.de_out), 32'(e_de));
        chk("cyc_hsync", 32'(vid.hsync_out), 32'(e_hs));
        chk("cyc_vsync", 32'(vid.vsync_out), 32'(e_vs));
        chk("cyc_frame_start", 32'(vid.frame_start), 32'(e_fs));
        chk("cyc_pixel", 32'(vid.pixel_out), 32'(e_pix));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [23:0] cap_pix [F_TOT];
  logic        cap_de  [F_TOT];
  logic        cap_hs  [F_TOT];
  logic        cap_vs  [F_TOT];
  logic        cap_fs  [F_TOT];

  initial begin
    int n_de;
    int n_hs;
    int n_vs;
    int n_fs;
    int n;
    bit found;
    logic [31:0] g5;

    g5 = (SCROLL != 0) ? 32'h060606 : 32'h050505;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_de", 32'(vid.de_out), 32'h0);
    chk("rst_hsync", 32'(vid.hsync_out), 32'h0);
    chk("rst_vsync", 32'(vid.vsync_out), 32'h0);
    chk("rst_pixel", 32'(vid.pixel_out), 32'h0);
    chk("rst_frame_start", 32'(vid.frame_start), 32'h0);
    $display("[TB] reset state checked");

    // Frame 0: bars, select switched to gradient on line 2
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < F_TOT; i++) begin
      @(negedge clk);
      cap_pix[i] = vid.pixel_out;
      cap_de[i]  = vid.de_out;
      cap_hs[i]  = vid.hsync_out;
      cap_vs[i]  = vid.vsync_out;
      cap_fs[i]  = vid.frame_start;
      if (i == 2 * H_TOT) pattern_sel = 2'd1;
    end
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    for (int i = 0; i < F_TOT; i++) begin
      n_de += int'(cap_de[i]);
      n_hs += int'(cap_hs[i]);
      n_vs += int'(cap_vs[i]);
      n_fs += int'(cap_fs[i]);
    end
    chk("f0_first_frame_start", 32'(cap_fs[0]), 32'h1);
    chk("f0_first_pixel", 32'(cap_pix[0]), 32'hFFFFFF);
    chk("f0_frame_start_count", n_fs, 1);
    chk("f0_de_count", n_de, 64);
    chk("f0_hsync_count", n_hs, 24);
    chk("f0_vsync_count", n_vs, 48);
    chk("f0_hsync_h17", 32'(cap_hs[17]), 32'h0);
    chk("f0_hsync_h18", 32'(cap_hs[18]), 32'h1);
    chk("f0_hsync_h20", 32'(cap_hs[20]), 32'h1);
    chk("f0_hsync_h21", 32'(cap_hs[21]), 32'h0);
    chk("f0_vsync_before_line5", 32'(cap_vs[119]), 32'h0);
    chk("f0_vsync_line5_start", 32'(cap_vs[120]), 32'h1);
    chk("f0_vsync_line6_end", 32'(cap_vs[167]), 32'h1);
    chk("f0_vsync_line7", 32'(cap_vs[168]), 32'h0);
    for (int h = 0; h < H_ACT; h++) chk($sformatf("f0_bar_px%0d", h), 32'(cap_pix[h]), 32'(BAR_LIT[h / 2]));
    for (int h = H_ACT; h < H_TOT; h++) chk($sformatf("f0_blank_px%0d", h), 32'(cap_pix[h]), 32'h0);
    chk("f0_line3_px0_still_bars", 32'(cap_pix[3 * H_TOT]), 32'hFFFFFF);
    chk("f0_line3_px6_still_bars", 32'(cap_pix[3 * H_TOT + 6]), 32'h00FF00);
    $display("[TB] frame timing and colour bars checked");

    // Frame 1: gradient takes effect, then freeze for 10 clocks mid-line 1
    @(negedge clk);
    chk("f1_frame_start", 32'(vid.frame_start), 32'h1);
    chk("f1_px0", 32'(vid.pixel_out), (SCROLL != 0) ? 32'h010101 : 32'h000000);
    n = 0;
    repeat (5) begin @(negedge clk); n++; end
    chk("f1_px5", 32'(vid.pixel_out), g5);
    repeat (H_TOT) begin @(negedge clk); n++; end
    chk("f1_line1_px5", 32'(vid.pixel_out), g5);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      chk("freeze_pixel", 32'(vid.pixel_out), g5);
      chk("freeze_de", 32'(vid.de_out), 32'h1);
      chk("freeze_frame_start", 32'(vid.frame_start), 32'h0);
    end
    en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      n++;
      if (vid.frame_start === 1'b1) found = 1'b1;
    end
    chk("freeze_next_frame_seen", 32'(found), 32'h1);
    chk("freeze_frame_length", n, 202);
    $display("[TB] pattern switch and enable freeze checked");

    // Reset at line 6 of frame 2
    repeat (6 * H_TOT) @(negedge clk);
    chk("prerst_vsync", 32'(vid.vsync_out), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_de", 32'(vid.de_out), 32'h0);
    chk("midrst_hsync", 32'(vid.hsync_out), 32'h0);
    chk("midrst_vsync", 32'(vid.vsync_out), 32'h0);
    chk("midrst_pixel", 32'(vid.pixel_out), 32'h0);
    chk("midrst_frame_start", 32'(vid.frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_frame_start", 32'(vid.frame_start), 32'h1);
    chk("postrst_de", 32'(vid.de_out), 32'h1);
    chk("postrst_px0", 32'(vid.pixel_out), 32'h000000);
    $display("[TB] mid-operation reset checked");

    // Frame 3 pixel 0 (scroll offset 3 when enabled), then solid and checker
    repeat (3 * F_TOT) @(negedge clk);
    chk("f3_frame_start", 32'(vid.frame_start), 32'h1);
    chk("f3_px0", 32'(vid.pixel_out), (SCROLL != 0) ? 32'h030303 : 32'h000000);
    repeat (F_TOT - 1) @(negedge clk);
    pattern_sel = 2'd2;
    @(negedge clk);
    chk("f4_frame_start", 32'(vid.frame_start), 32'h1);
    chk("f4_solid_px0", 32'(vid.pixel_out), 32'hE0A080);
    pattern_sel = 2'd3;
    repeat (F_TOT + 2 * H_TOT) @(negedge clk);
    $display("[TB] scroll, solid and checker frames checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/video_stream_gen.md
# video_stream_gen

Synthesisable video source that produces the same `de`/`hsync`/`vsync`/24-bit RGB stream the vision pipeline consumes. It is the transmit end of that interface. It generates raster timing from parameterised porch and sync counts and fills active pixels with one of four test patterns. It drives the vision pipeline on board when no HDMI input is present, and acts as the stimulus source in pipeline simulations.

## Interface

Parameters:
- `H_ACTIVE`, 1280: active pixels per line. Must be a multiple of 8 and ≥ 8.
- `H_FP`, 110: horizontal front porch, in clocks.
- `H_SYNC`, 40: hsync width, in clocks.
- `H_BP`, 220: horizontal back porch, in clocks.
- `V_ACTIVE`, 720: active lines per frame.
- `V_FP`, 5: vertical front porch, in lines.
- `V_SYNC`, 5: vsync width, in lines.
- `V_BP`, 20: vertical back porch, in lines.
- `SYNC_POL`, 1: asserted level of `hsync_out`/`vsync_out`.

Ports:
- `clk` input 1: pixel clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: advance enable. When low, the whole block freezes.
- `pattern_sel` input 2: 0 = colour bars, 1 = gradient, 2 = solid, 3 = checkerboard.
- `de_out` output 1: active-video flag.
- `hsync_out` output 1: horizontal sync.
- `vsync_out` output 1: vertical sync.
- `pixel_out` output 24: {R,G,B}.
- `frame_start` output 1: one-clock pulse coincident with pixel (0,0) on the outputs.

## Operation

- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
  - `v_cnt` wraps to 0 after V_TOTAL-1, at the same edge on which `h_cnt` wraps.
- Region order along each axis: active, front porch, sync, back porch.
- Output derivation:
  - `de` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is asserted while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is asserted for whole lines where V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. Its edges occur at h_cnt = 0.
- Patterns, evaluated at x = h_cnt, y = v_cnt:
  - Bars: 8 bars, each H_ACTIVE/8 wide, in the order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
    - Bar index comes from a bar-width down-counter reloaded at h_cnt = 0. No divider is used.
  - Gradient: {x[7:0], x[7:0], x[7:0]}.
  - Solid: E0A080.
  - Checker: FFFFFF if x[4]^y[4], else 000000.
- `pixel_out` is 000000 whenever `de` is 0.
- `pattern_sel` is latched into an internal register only when counters are at (0,0) with `en` = 1. A change mid-frame takes effect at the next frame.
- `en` = 0 holds the counters, all output registers and the latched pattern. When `en` returns to 1, output resumes exactly where it stopped.

## Timing

- Counters and outputs are registered. Outputs reflect the counter state of the previous enabled clock, giving a latency of 1 clock.
- Reset values:
  - `h_cnt` = 0, `v_cnt` = 0.
  - `de_out` = 0, `hsync_out` = `vsync_out` = ~SYNC_POL.
  - `pixel_out` = 0, `frame_start` = 0.
  - Latched pattern = 0.
- First edge with `rst` = 0 and `en` = 1: outputs show pixel (0,0) with `de_out` = 1 and `frame_start` = 1. At this edge the block also latches `pattern_sel`.
- Reset mid-frame: all of the above values are applied on the next edge. The next frame then starts cleanly, with no partial line.
- `rst` has priority over `en`.

## Configuration

- `VSG_SCROLL_EN` defined:
  - Adds an 8-bit frame counter that increments at each frame wrap.
  - Pattern x becomes (h_cnt + frame_cnt) for gradient and checker only. Bars are unaffected.
  - The counter resets to 0 and holds while `en` = 0.
- Undefined: no frame counter exists and patterns are static.

## Structure

- Package `video_pkg`:
  - 1280×720 timing constants.
  - Pattern-select encoding constants.
  - 24-bit colour constants for the bars, solid and checker.
- Sub-module `video_pattern_lut` is combinational. It maps (pattern, x, y, bar index) to RGB.
- The top level holds the counters, latching and output registers.

## Test plan

All scenarios use the small-frame parameters H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL = 24) and V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL = 8), with SYNC_POL=1.

- **Reset and frame timing.** Reset, release with `en` = 1.
  - `frame_start` pulses on clock 1, then every 192 clocks.
  - `de_out` is high for 16 clocks in each of lines 0–3 (64 per frame).
  - hsync is high at h = 18–20.
  - vsync is high for lines 5–6, i.e. 48 clocks.
- **Colour bars.** `pattern_sel` = 0.
  - Line 0 pixels 0–1 = FFFFFF, 2–3 = FFFF00, …, 14–15 = 000000.
  - Blanking pixels = 000000.
- **Mid-frame pattern change.** Switch `pattern_sel` from 0 to 1 at line 2.
  - The rest of the frame stays bars.
  - The next frame's pixel 5 = 050505.
- **Enable freeze.** Drop `en` for 10 clocks mid-line 1.
  - All outputs stay constant.
  - After `en` returns, the remaining sequence is identical to an unstalled run, with the frame length extended by exactly 10 clocks.
- **Reset mid-operation.** Assert `rst` at line 6.
  - The next edge gives the reset values listed under Timing.
  - The first edge after release gives `frame_start` = 1 with pixel (0,0).
- **Scroll (`VSG_SCROLL_EN`).** Gradient pattern.
  - Frame 0 pixel 0 = 000000.
  - Frame 3 pixel 0 = 030303.
